fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core. Sits directly upstream of the next-PC logic.
- Owns the architectural fetch PC (pc_F) and drives the instruction-memory request. pc_F is fed to the next-PC logic, which returns npc.
- Produces the IF/ID pipeline register contents for decode.
- Tolerates a variable-latency instruction memory through a req/ready handshake. Also supports hazard stall, redirect flush and fetch-address-error tagging.

Parameters:
- RESET_PC, 32'h0000_3000, pc_F value at reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_LIMIT, 32'h0000_6FFC, highest legal fetch word address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- npc  in  32  next PC from next-PC logic; sampled only when the stage advances or flushes.
- stall  in  1  hazard-unit stall; freezes IF/ID and pc_F.
- flush  in  1  redirect; kill IF/ID contents and buffered word, load npc.
- imem_req  out  1  fetch request for imem_addr.
- imem_addr  out  32  always equal to pc_F.
- imem_rdata  in  32  instruction word; valid only when imem_ready=1.
- imem_ready  in  1  rdata valid for the imem_addr of the same cycle.
- pc_F  out  32  current fetch PC.
- fetch_busy  out  1  fetch waiting on memory (state REQ, legal address, imem_ready=0).
- instr_D  out  32  IF/ID instruction.
- pc_D  out  32  IF/ID PC.
- pc8_D  out  32  pc_D+8, modulo 2^32, for link writes.
- valid_D  out  1  IF/ID holds a real instruction.
- adel_D  out  1  IF/ID entry carries a fetch address error.

Behaviour:
- Reset (reset=0, asynchronous, any state, any time):
  - pc_F=RESET_PC, state=REQ, ibuf cleared.
  - instr_D=0, pc_D=0, valid_D=0, adel_D=0.
  - Outstanding memory data is discarded.
- Address check: bad = (pc_F[1:0]!=0) or pc_F<IMEM_BASE or pc_F>IMEM_LIMIT.
  - If bad: imem_req=0 and the fetch completes internally this cycle with word=0 and adel=1.
- States:
  - REQ: imem_req = !bad. done = imem_ready | bad.
  - HOLD: a completed word and its adel bit sit in ibuf. imem_req=0.
- Priority per edge: reset > flush > stall > normal.
- flush=1, any state:
  - IF/ID <= bubble (valid_D=0, instr_D=0, adel_D=0).
  - pc_F <= npc, ibuf dropped, state <= REQ.
  - flush overrides a simultaneous stall.
- REQ, done=1, stall=0: IF/ID <= {pc_F, word, valid=1, adel}; pc_F <= npc; stay in REQ.
- REQ, done=1, stall=1: ibuf <= {word, adel}; state <= HOLD; pc_F and IF/ID unchanged.
- REQ, done=0, stall=0: IF/ID <= bubble; pc_F unchanged.
- REQ, done=0, stall=1: everything holds.
- HOLD, stall=0: IF/ID <= {pc_F, ibuf, valid=1}; pc_F <= npc; state <= REQ.
- HOLD, stall=1: hold.
- Latency: zero-wait memory gives 1 instruction per cycle; an instruction reaches IF/ID on the edge after ready.
- Memory contract: imem_addr may change while req is held; ready always refers to the current address.
- pc_F wraps modulo 2^32; a wrapped address is caught as bad.
- bubble encoding: instr_D=0 (sll $0 nop).

Decomposition:
- Shared package mips_defs holds: RESET_PC, IMEM_BASE, IMEM_LIMIT, NOP_INSTR=32'h0, and the fetch state encoding (REQ=1'b0, HOLD=1'b1).
- One sub-module, if_id_reg: holds the IF/ID register with load/bubble/hold controls and generates pc8_D.
- FSM, pc_F register, ibuf and address check stay in fetch_stage.

Test Plan:
- Reset: assert reset=0 mid-fetch in HOLD → immediately pc_F=0x3000, valid_D=0, instr_D=0. After release, imem_req=1 and imem_addr=0x3000.
- Zero-wait: imem_ready=1 every cycle, npc=pc_F+4, words 0x24010001, 0x24020002 → instr_D follows one per cycle, pc_D=0x3000 then 0x3004, pc8_D=0x3008 then 0x300C.
- 2-cycle memory: ready only every 3rd cycle → fetch_busy=1 for 2 cycles, valid_D=0 bubbles between instructions, pc_F held during waits.
- Stall on ready: at pc_F=0x3008, ready=1, rdata=0x8C030000, stall=1 for 3 cycles → HOLD, imem_req=0, IF/ID frozen. On release: instr_D=0x8C030000, pc_D=0x3008, pc_F=npc.
- Flush in HOLD with stall=1, npc=0x4180 → pc_F=0x4180, valid_D=0, buffered 0x8C030000 never appears, imem_req=1.
- Bad address: npc=0x3002 → imem_req=0; next edge instr_D=0, pc_D=0x3002, adel_D=1, valid_D=1. Likewise pc_F=0x7000 gives adel_D=1.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the MIPS pipeline: memory map, bubble encoding and fetch FSM states.
package mips_defs;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IMEM_LIMIT = 32'h0000_6FFC;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with bubble/load/hold control; also derives the link address pc+8.
module if_id_reg
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        adel_in,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        valid_D,
    output logic        adel_D
);

    // Bubble wins over load; with neither asserted the entry holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_D <= NOP_INSTR;
            pc_D    <= 32'h0;
            valid_D <= 1'b0;
            adel_D  <= 1'b0;
        end else if (bubble) begin
            instr_D <= NOP_INSTR;
            valid_D <= 1'b0;
            adel_D  <= 1'b0;
        end else if (load) begin
            instr_D <= instr_in;
            pc_D    <= pc_in;
            valid_D <= 1'b1;
            adel_D  <= adel_in;
        end
    end

    assign pc8_D = pc_D + 32'd8;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns pc_F, talks to a variable-latency imem, buffers a word across stalls.
module fetch_stage
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC   = mips_defs::RESET_PC,
    parameter logic [31:0] IMEM_BASE  = mips_defs::IMEM_BASE,
    parameter logic [31:0] IMEM_LIMIT = mips_defs::IMEM_LIMIT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_F,
    output logic        fetch_busy,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        valid_D,
    output logic        adel_D
);

    fetch_state_t state, next_state;
    logic [31:0]  next_pc;
    logic [31:0]  ibuf_instr;
    logic         ibuf_adel;
    logic         ibuf_wr;
    logic         ibuf_clr;
    logic         bad;
    logic         done;
    logic [31:0]  word;
    logic         ld_load;
    logic         ld_bubble;
    logic [31:0]  ld_instr;
    logic         ld_adel;

    // Misaligned or out-of-window addresses (including wrapped ones) never reach memory.
    assign bad  = (pc_F[1:0] != 2'b00) || (pc_F < IMEM_BASE) || (pc_F > IMEM_LIMIT);
    assign word = bad ? NOP_INSTR : imem_rdata;
    assign done = (state == REQ) && (imem_ready || bad);

    assign imem_addr  = pc_F;
    assign imem_req   = (state == REQ) && !bad;
    assign fetch_busy = (state == REQ) && !bad && !imem_ready;

    // State, fetch PC and the stall buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= REQ;
            pc_F       <= RESET_PC;
            ibuf_instr <= NOP_INSTR;
            ibuf_adel  <= 1'b0;
        end else begin
            state <= next_state;
            pc_F  <= next_pc;
            if (ibuf_clr) begin
                ibuf_instr <= NOP_INSTR;
                ibuf_adel  <= 1'b0;
            end else if (ibuf_wr) begin
                ibuf_instr <= word;
                ibuf_adel  <= bad;
            end
        end
    end

    // Next-state and IF/ID control; priority is flush, then stall, then normal flow.
    always_comb begin
        next_state = state;
        next_pc    = pc_F;
        ibuf_wr    = 1'b0;
        ibuf_clr   = 1'b0;
        ld_load    = 1'b0;
        ld_bubble  = 1'b0;
        ld_instr   = word;
        ld_adel    = bad;
        if (flush) begin
            ld_bubble  = 1'b1;
            ibuf_clr   = 1'b1;
            next_pc    = npc;
            next_state = REQ;
        end else if (state == REQ) begin
            if (done && !stall) begin
                ld_load = 1'b1;
                next_pc = npc;
            end else if (done && stall) begin
                ibuf_wr    = 1'b1;
                next_state = HOLD;
            end else if (!stall) begin
                ld_bubble = 1'b1;
            end
        end else begin
            if (!stall) begin
                ld_load    = 1'b1;
                ld_instr   = ibuf_instr;
                ld_adel    = ibuf_adel;
                next_pc    = npc;
                next_state = REQ;
            end
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (ld_load),
        .bubble   (ld_bubble),
        .pc_in    (pc_F),
        .instr_in (ld_instr),
        .adel_in  (ld_adel),
        .instr_D  (instr_D),
        .pc_D     (pc_D),
        .pc8_D    (pc8_D),
        .valid_D  (valid_D),
        .adel_D   (adel_D)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID entries, a monitor pops and compares.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc_F;
    logic        fetch_busy;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        valid_D;
    logic        adel_D;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        adel;
    } entry_t;

    entry_t      sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        use_seq = 1'b0;
    logic [31:0] npc_force = 32'h0;
    logic        edge_held = 1'b0;

    // Stand-in for the next-PC logic: sequential pc+4 or a forced redirect target.
    assign npc = use_seq ? (pc_F + 32'd4) : npc_force;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall      (stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc_F       (pc_F),
        .fetch_busy (fetch_busy),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .pc8_D      (pc8_D),
        .valid_D    (valid_D),
        .adel_D     (adel_D)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic expectEntry(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc8, input logic adel);
        entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.pc8   = pc8;
        e.adel  = adel;
        sb_q.push_back(e);
    endtask

    // Inputs change just after an edge; combinational outputs are settled by the time the task returns.
    task automatic applyStimulus(input logic st, input logic fl, input logic rdy, input logic [31:0] rd);
        stall      = st;
        flush      = fl;
        imem_ready = rdy;
        imem_rdata = rd;
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    // Record whether the coming edge leaves IF/ID frozen, so a held entry is not counted twice.
    always @(posedge clk) begin
        edge_held = stall && !flush;
    end

    // Monitor: every fresh valid IF/ID entry must match the oldest expected entry.
    always @(posedge clk) begin
        #3;
        if (reset && valid_D && !edge_held) begin
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("[TB] FAIL unexpected_entry: got instr 0x%08h pc 0x%08h, expected none", instr_D, pc_D);
            end else begin
                entry_t e;
                e = sb_q.pop_front();
                checkOutput("sb_instr_D", instr_D, e.instr);
                checkOutput("sb_pc_D", pc_D, e.pc);
                checkOutput("sb_pc8_D", pc8_D, e.pc8);
                checkOutput("sb_adel_D", {31'h0, adel_D}, {31'h0, e.adel});
            end
        end
    end

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) clockEdge();
        checkOutput("rst_pc_F", pc_F, 32'h3000);
        checkOutput("rst_valid_D", {31'h0, valid_D}, 32'h0);
        checkOutput("rst_instr_D", instr_D, 32'h0);
        checkOutput("rst_pc_D", pc_D, 32'h0);
        checkOutput("rst_adel_D", {31'h0, adel_D}, 32'h0);
        @(negedge clk);
        reset   = 1'b1;
        use_seq = 1'b1;
        #1;
        checkOutput("rel_imem_req", {31'h0, imem_req}, 32'h1);
        checkOutput("rel_imem_addr", imem_addr, 32'h3000);
        clockEdge();

        // Zero-wait memory: one instruction per cycle.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h24010001);
        checkOutput("zw_busy", {31'h0, fetch_busy}, 32'h0);
        expectEntry(32'h24010001, 32'h3000, 32'h3008, 1'b0);
        clockEdge();
        checkOutput("zw_pc_F0", pc_F, 32'h3004);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h24020002);
        expectEntry(32'h24020002, 32'h3004, 32'h300C, 1'b0);
        clockEdge();
        checkOutput("zw_pc_F1", pc_F, 32'h3008);

        // Stall while ready: word goes to the buffer, IF/ID and pc_F freeze.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h8C030000);
        clockEdge();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput("st_imem_req", {31'h0, imem_req}, 32'h0);
            checkOutput("st_pc_F", pc_F, 32'h3008);
            checkOutput("st_instr_D", instr_D, 32'h24020002);
            checkOutput("st_pc_D", pc_D, 32'h3004);
            clockEdge();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        expectEntry(32'h8C030000, 32'h3008, 32'h3010, 1'b0);
        clockEdge();
        checkOutput("st_rel_pc_F", pc_F, 32'h300C);
        checkOutput("st_rel_req", {31'h0, imem_req}, 32'h1);

        // Two-wait memory: busy for two cycles, bubbles in between.
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 2; w++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
                checkOutput("w2_busy", {31'h0, fetch_busy}, 32'h1);
                clockEdge();
                checkOutput("w2_bubble", {31'h0, valid_D}, 32'h0);
                checkOutput("w2_pc_F", pc_F, (k == 0) ? 32'h300C : 32'h3010);
            end
            applyStimulus(1'b0, 1'b0, 1'b1, (k == 0) ? 32'h00000020 : 32'h00851020);
            checkOutput("w2_busy_rdy", {31'h0, fetch_busy}, 32'h0);
            if (k == 0) expectEntry(32'h00000020, 32'h300C, 32'h3014, 1'b0);
            else        expectEntry(32'h00851020, 32'h3010, 32'h3018, 1'b0);
            clockEdge();
        end
        checkOutput("w2_pc_F_end", pc_F, 32'h3014);

        // Flush while holding a buffered word: the word must be dropped.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h8C030000);
        clockEdge();
        checkOutput("fl_hold_req", {31'h0, imem_req}, 32'h0);
        use_seq   = 1'b0;
        npc_force = 32'h4180;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        clockEdge();
        checkOutput("fl_pc_F", pc_F, 32'h4180);
        checkOutput("fl_valid_D", {31'h0, valid_D}, 32'h0);
        checkOutput("fl_instr_D", instr_D, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("fl_req", {31'h0, imem_req}, 32'h1);
        clockEdge();
        npc_force = 32'h3002;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h12345678);
        expectEntry(32'h12345678, 32'h4180, 32'h4188, 1'b0);
        clockEdge();

        // Bad addresses: misaligned, above limit, below base, wrapped.
        checkOutput("bad_pc_F", pc_F, 32'h3002);
        npc_force = 32'h7000;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("bad_mis_req", {31'h0, imem_req}, 32'h0);
        checkOutput("bad_mis_busy", {31'h0, fetch_busy}, 32'h0);
        expectEntry(32'h0, 32'h3002, 32'h300A, 1'b1);
        clockEdge();
        npc_force = 32'h6FFC;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("bad_hi_req", {31'h0, imem_req}, 32'h0);
        expectEntry(32'h0, 32'h7000, 32'h7008, 1'b1);
        clockEdge();
        npc_force = 32'h2FFC;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hAAAA5555);
        checkOutput("lim_req", {31'h0, imem_req}, 32'h1);
        expectEntry(32'hAAAA5555, 32'h6FFC, 32'h7004, 1'b0);
        clockEdge();
        npc_force = 32'hFFFFFFFC;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h11111111);
        checkOutput("bad_lo_req", {31'h0, imem_req}, 32'h0);
        expectEntry(32'h0, 32'h2FFC, 32'h3004, 1'b1);
        clockEdge();
        npc_force = 32'h3004;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("bad_wrap_req", {31'h0, imem_req}, 32'h0);
        expectEntry(32'h0, 32'hFFFFFFFC, 32'h00000004, 1'b1);
        clockEdge();

        // Asynchronous reset in the middle of a HOLD.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
        clockEdge();
        checkOutput("rh_hold_req", {31'h0, imem_req}, 32'h0);
        reset = 1'b0;
        #1;
        checkOutput("rh_pc_F", pc_F, 32'h3000);
        checkOutput("rh_valid_D", {31'h0, valid_D}, 32'h0);
        checkOutput("rh_instr_D", instr_D, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rh_req", {31'h0, imem_req}, 32'h1);
        checkOutput("rh_addr", imem_addr, 32'h3000);
        repeat (2) clockEdge();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
